serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
Bit-serial subtractor that computes a - b - bin over WIDTH clock cycles, LSB first. It is the inverse operation of the team's combinational full-adder cell. Each cycle, one full-subtractor stage (difference/borrow) runs with a registered borrow, so a wide subtraction costs one cell plus shift registers. It sits next to the adder blocks in the arithmetic library and uses a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1 to 32)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; operands sampled on the edge where start=1 and the block is not busy
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when diff and bout become valid
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow-out: 1 when a < b + bin (unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, bit counter and borrow flop all cleared. Reset mid-operation aborts the operation silently, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, load sa<=a, sb<=b, brw<=bin, cnt<=0, go to RUN. Otherwise stay.
- RUN: each edge:
  - d = sa[0]^sb[0]^brw
  - brw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw)
  - sa and sb shift right by 1
  - d shifts into the MSB of the internal result register sr
  - cnt increments
  - On the edge that processes bit WIDTH-1: load diff with the completed result, bout with the final borrow, and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. A start in DONE is accepted exactly as in IDLE, going directly to RUN, so back-to-back operations are possible.
- busy=1 in RUN only. done=1 in DONE only. Both are registered state decodes.
- start while RUN is ignored: no reload, no error flag.
- Latency: start sampled at edge k, done high during the cycle after edge k+WIDTH, so done is visible WIDTH+1 cycles after start.
- diff and bout change only at the completion edge. They hold their value through DONE and IDLE until the next completion or reset, and never show partial results.
- Operand inputs are don't-care except at the start edge.
- The counter is sized clog2(WIDTH+1) and never wraps past WIDTH-1. With WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^WIDTH. The result satisfies {bout,diff} == {1'b0,a} - b - bin taken as (WIDTH+1)-bit two's complement, where bout equals the sign bit.

Decomposition:
- Package serial_arith_pkg:
  - state enum (IDLE, RUN, DONE)
  - clog2-based counter-width constant function
- Sub-module fs_cell: combinational full subtractor.
  - Inputs: x, y, bi. Outputs: d, bo.
  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
  - Instantiated once inside serial_sub.
  - Unit-tested on its own across all 8 input combinations.

Test Plan:
1. WIDTH=8, a=100, b=37, bin=0, start one cycle -> busy high for 8 cycles; done pulses once 9 cycles after start; diff=63 (0x3F), bout=0.
2. a=37, b=100, bin=0 -> diff=193 (0xC1), bout=1. Then a=0, b=0, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
3. Start (a=200, b=50), then pulse start with a=1, b=2 at cycle 3 of RUN -> second request ignored; result diff=150, bout=0; exactly one done pulse.
4. Assert start during the DONE cycle with a=10, b=3 -> no IDLE gap; next done 9 cycles later with diff=7; previous diff held until then.
5. Drop rst_n at cycle 4 of RUN (a=9, b=4) -> busy, done, diff and bout go to 0 immediately, asynchronously; no done pulse. After release, a fresh start with a=9, b=4 gives diff=5.
6. WIDTH=1, exhaustive over a, b, bin (8 cases) -> done 2 cycles after each start; {bout,diff} matches the full-subtractor truth table and matches fs_cell standalone. Plus 1000 random WIDTH=8 vectors checked against the (WIDTH+1)-bit reference model.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   cnt_w() : width of a bit counter that must hold 0..w
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for counting 0..w. At least one bit, even for w=1.
  function automatic int cnt_w(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational full subtractor: x - y - bi.
//   x, y : operand bits
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when x < y, or when x == y and a borrow is already pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first.
//   clk, rst_n : clock, async active-low reset
//   start      : request; sampled when IDLE or DONE
//   a, b, bin  : minuend, subtrahend, borrow-in (sampled at start)
//   busy       : high in RUN
//   done       : one-cycle pulse when diff/bout are updated
//   diff, bout : result and final borrow; held until next completion
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr, sr_nxt;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d, bo;
  logic             accept, last;

  fs_cell u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_sr1
      assign sr_nxt = d;
    end else begin : g_srn
      assign sr_nxt = {d, sr[WIDTH-1:1]};
    end
  endgenerate

  // DONE accepts a start like IDLE so operations can run back to back.
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      brw <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_nxt;
      brw <= bo;
      if (last) begin
        // Outputs only ever see a finished result.
        cnt  <= '0;
        diff <= sr_nxt;
        bout <= bo;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  import serial_arith_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  logic fx = 1'b0, fy = 1'b0, fbi = 1'b0, fd, fbo;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  fs_cell u_fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one WIDTH=8 op; checks busy every RUN cycle, latency, result.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                      input logic [7:0] ed, input logic eb, input bit chk_busy);
    int n;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hxx; b = 8'hxx;
    n = 1;
    while (!done && n < 20) begin
      if (chk_busy) chk("busy_run", busy, 1);
      @(negedge clk);
      n++;
    end
    chk("latency8", n, 9);
    chk("done8", done, 1);
    chk("busy_done", busy, 0);
    chk("diff8", diff, ed);
    chk("bout8", bout, eb);
  endtask

  task automatic run1(input logic ta, input logic tb_, input logic tbin,
                      input logic ed, input logic eb);
    int n;
    @(negedge clk);
    a1 = ta; b1 = tb_; bin1 = tbin; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency1", n, 2);
    chk("diff1", diff1, ed);
    chk("bout1", bout1, eb);
  endtask

  vec_t vt[6];
  // Full-subtractor truth table indexed by {x,y,bi}: {bo,d}.
  logic [1:0] fs_tt [8];

  initial begin
    int n, ndone;
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rbin;

    vt[0] = '{8'd100, 8'd37,  1'b0, 8'h3F, 1'b0};
    vt[1] = '{8'd37,  8'd100, 1'b0, 8'hC1, 1'b1};
    vt[2] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h80,  8'h01,  1'b1, 8'h7E, 1'b0};
    vt[5] = '{8'h05,  8'h05,  1'b1, 8'hFF, 1'b1};

    fs_tt[0] = 2'b00; fs_tt[1] = 2'b11; fs_tt[2] = 2'b11; fs_tt[3] = 2'b10;
    fs_tt[4] = 2'b01; fs_tt[5] = 2'b00; fs_tt[6] = 2'b00; fs_tt[7] = 2'b11;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tests 1-2 and extras: table-driven
    for (int i = 0; i < 6; i++)
      run8(vt[i].a, vt[i].b, vt[i].bin, vt[i].diff, vt[i].bout, 1'b1);

    // Test 3: start during RUN is ignored
    @(negedge clk);
    a = 8'd200; b = 8'd50; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; ndone = 0;
    while (!done && n < 20) begin
      if (n == 3) begin a = 8'd1; b = 8'd2; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("ign_latency", n, 9);
    chk("ign_diff", diff, 150);
    chk("ign_bout", bout, 0);

    // Test 4: start in DONE cycle, no IDLE gap, previous diff held
    a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      chk("b2b_busy", busy, 1);
      chk("b2b_hold", diff, 150);
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", n, 9);
    chk("b2b_diff", diff, 7);
    chk("b2b_bout", bout, 0);
    @(negedge clk);
    chk("done_once", done, 0);

    // Test 5: async reset mid-RUN
    a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    chk("arst_bout", bout, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    run8(8'd9, 8'd4, 1'b0, 8'd5, 1'b0, 1'b0);

    // Test 6: WIDTH=1 exhaustive and fs_cell standalone
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      fx = idx[2]; fy = idx[1]; fbi = idx[0];
      #1;
      chk("fs_cell", {fbo, fd}, fs_tt[i]);
      run1(idx[2], idx[1], idx[0], fs_tt[i][0], fs_tt[i][1]);
    end

    // Random WIDTH=8 vectors against the 9-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      run8(ra, rb, rbin, ref9[7:0], ref9[8], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
